// File: rtl/if_trace_pkg.sv
// Shared types for the instruction-fetch trace collector: record layouts and FIFO sizing.
package if_trace_pkg;

   localparam int IFT_ADDR_W          = 32;
   localparam int IFT_DATA_W          = 32;
   localparam int IFT_CNT_W           = 32;
   localparam int IFT_MAX_OUTSTANDING = 4;
   localparam int IFT_OUT_DEPTH       = 8;
   localparam int IFT_INFL_PTR_W      = $clog2(IFT_MAX_OUTSTANDING);
   localparam int IFT_OUT_PTR_W       = $clog2(IFT_OUT_DEPTH);

   typedef struct packed {
      logic [IFT_ADDR_W-1:0] addr;
      logic [IFT_DATA_W-1:0] instr;
      logic [IFT_CNT_W-1:0]  req_start;
      logic [IFT_CNT_W-1:0]  req_end;
      logic [IFT_CNT_W-1:0]  res_start;
      logic [IFT_CNT_W-1:0]  res_end;
   } ift_record_t;

   typedef struct packed {
      logic [IFT_ADDR_W-1:0] addr;
      logic [IFT_CNT_W-1:0]  req_start;
      logic [IFT_CNT_W-1:0]  req_end;
      logic [IFT_CNT_W-1:0]  res_start;
   } ift_pending_t;

endpackage

// File: rtl/ift_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a push while full is accepted only alongside a pop.
module ift_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PW:0]      wptr_r;
   logic [PW:0]      rptr_r;
   logic             do_push_s;
   logic             do_pop_s;

   always_comb begin
      do_pop_s  = pop & ~empty;
      do_push_s = push & (~full | do_pop_s);
   end

   assign empty = (wptr_r == rptr_r);
   assign full  = (wptr_r[PW] != rptr_r[PW]) && (wptr_r[PW-1:0] == rptr_r[PW-1:0]);
   assign count = wptr_r - rptr_r;
   assign rdata = mem_r[rptr_r[PW-1:0]];

   // Storage is cleared on reset so the head reads as zero until the first push.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_r <= '0;
         rptr_r <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else begin
         if (do_push_s) begin
            mem_r[wptr_r[PW-1:0]] <= wdata;
            wptr_r <= wptr_r + (PW+1)'(1);
         end
         if (do_pop_s) begin
            rptr_r <= rptr_r + (PW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/if_trace_collector.sv
// Snoops the instruction-memory bus and emits one timestamped record per completed fetch.
// Optional IFT_DROP_COUNT_EN adds a saturating drop_count output.
module if_trace_collector
   import if_trace_pkg::*;
#(
   parameter int ADDR_WIDTH      = IFT_ADDR_W,
   parameter int DATA_WIDTH      = IFT_DATA_W,
   parameter int CNT_WIDTH       = IFT_CNT_W,
   parameter int MAX_OUTSTANDING = IFT_MAX_OUTSTANDING,
   parameter int OUT_DEPTH       = IFT_OUT_DEPTH
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               instr_req,
   input  logic                               instr_gnt,
   input  logic [ADDR_WIDTH-1:0]              instr_addr,
   input  logic                               instr_rvalid,
   input  logic [DATA_WIDTH-1:0]              instr_rdata,
   input  logic [CNT_WIDTH-1:0]               counter,
   output logic                               trace_valid,
   input  logic                               trace_ready,
   output ift_record_t                        trace_data,
   output logic [$clog2(MAX_OUTSTANDING):0]   inflight_count,
   output logic                               overflow,
   output logic                               proto_err
`ifdef IFT_DROP_COUNT_EN
   ,
   output logic [15:0]                        drop_count
`endif
);

   logic                            req_open_r;
   logic [CNT_WIDTH-1:0]            req_start_r;
   ift_pending_t                    pend_s;
   ift_pending_t                    head_s;
   ift_record_t                     rec_s;
   logic                            infl_push_s;
   logic                            infl_pop_s;
   logic                            infl_full_s;
   logic                            infl_empty_s;
   logic                            out_pop_s;
   logic                            out_full_s;
   logic                            out_empty_s;
   logic [$clog2(OUT_DEPTH):0]      out_count_unused;
   logic                            gnt_drop_s;
   logic                            rv_drop_s;
   logic                            ovf_drop_s;

   // A grant's own entry is not poppable in the same cycle, so rvalid on an empty queue is dropped.
   always_comb begin
      infl_push_s = instr_req & instr_gnt;
      infl_pop_s  = instr_rvalid & ~infl_empty_s;
      out_pop_s   = trace_valid & trace_ready;
      gnt_drop_s  = infl_push_s & infl_full_s & ~infl_pop_s;
      rv_drop_s   = instr_rvalid & infl_empty_s;
      ovf_drop_s  = infl_pop_s & out_full_s & ~out_pop_s;

      pend_s.addr      = instr_addr;
      pend_s.req_start = req_open_r ? req_start_r : counter;
      pend_s.req_end   = counter;
      pend_s.res_start = counter;

      rec_s.addr      = head_s.addr;
      rec_s.instr     = instr_rdata;
      rec_s.req_start = head_s.req_start;
      rec_s.req_end   = head_s.req_end;
      rec_s.res_start = head_s.res_start;
      rec_s.res_end   = counter;
   end

   // Tracks the start of a request that is waiting for its grant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_open_r  <= 1'b0;
         req_start_r <= '0;
      end else if (infl_push_s) begin
         req_open_r <= 1'b0;
      end else if (instr_req && !req_open_r) begin
         req_open_r  <= 1'b1;
         req_start_r <= counter;
      end else if (!instr_req) begin
         req_open_r <= 1'b0;
      end
   end

   ift_sync_fifo #(
      .WIDTH ($bits(ift_pending_t)),
      .DEPTH (MAX_OUTSTANDING)
   ) u_infl_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (infl_push_s),
      .pop   (infl_pop_s),
      .wdata (pend_s),
      .rdata (head_s),
      .full  (infl_full_s),
      .empty (infl_empty_s),
      .count (inflight_count)
   );

   ift_sync_fifo #(
      .WIDTH ($bits(ift_record_t)),
      .DEPTH (OUT_DEPTH)
   ) u_out_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (infl_pop_s),
      .pop   (out_pop_s),
      .wdata (rec_s),
      .rdata (trace_data),
      .full  (out_full_s),
      .empty (out_empty_s),
      .count (out_count_unused)
   );

   assign trace_valid = ~out_empty_s;

   // Sticky loss indicators, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow  <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         if (ovf_drop_s) begin
            overflow <= 1'b1;
         end
         if (gnt_drop_s || rv_drop_s) begin
            proto_err <= 1'b1;
         end
      end
   end

`ifdef IFT_DROP_COUNT_EN
   // At most one drop cause can fire per cycle, so a single increment suffices.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_count <= 16'h0000;
      end else if ((ovf_drop_s || gnt_drop_s || rv_drop_s) && (drop_count != 16'hFFFF)) begin
         drop_count <= drop_count + 16'h0001;
      end
   end
`endif

endmodule

// File: tb/tb_if_trace_collector.sv
// Directed and randomized bench for if_trace_collector against a queue-based reference model.
module tb_if_trace_collector;
   import if_trace_pkg::*;

   localparam int MAXO = 4;
   localparam int OD   = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_req, instr_gnt, instr_rvalid, trace_ready;
   logic [31:0] instr_addr, instr_rdata, counter;
   logic        trace_valid, overflow, proto_err;
   ift_record_t trace_data;
   logic [2:0]  inflight_count;
`ifdef IFT_DROP_COUNT_EN
   logic [15:0] drop_count;
`endif

   always #5 clk = ~clk;

   if_trace_collector dut (
      .clk            (clk),
      .rst            (rst),
      .instr_req      (instr_req),
      .instr_gnt      (instr_gnt),
      .instr_addr     (instr_addr),
      .instr_rvalid   (instr_rvalid),
      .instr_rdata    (instr_rdata),
      .counter        (counter),
      .trace_valid    (trace_valid),
      .trace_ready    (trace_ready),
      .trace_data     (trace_data),
      .inflight_count (inflight_count),
      .overflow       (overflow),
`ifdef IFT_DROP_COUNT_EN
      .drop_count     (drop_count),
`endif
      .proto_err      (proto_err)
   );

   ift_pending_t m_pend[$];
   ift_record_t  m_out[$];
   bit           m_open;
   logic [31:0]  m_start;
   bit           m_ovf, m_perr;
   int           m_drop;
   int           vectors = 0;
   int           miscompares = 0;

   task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pend.delete();
      m_out.delete();
      m_open = 0; m_start = '0; m_ovf = 0; m_perr = 0; m_drop = 0;
   endtask

   // Reference: consumer takes the head, responses retire the oldest fetch, grants enqueue.
   task automatic model_step();
      ift_pending_t p;
      ift_record_t  r;
      bit           drop = 0;
      if (m_out.size() > 0 && trace_ready) void'(m_out.pop_front());
      if (instr_rvalid) begin
         if (m_pend.size() == 0) begin
            m_perr = 1; drop = 1;
         end else begin
            p = m_pend.pop_front();
            r = '{addr: p.addr, instr: instr_rdata, req_start: p.req_start,
                  req_end: p.req_end, res_start: p.res_start, res_end: counter};
            if (m_out.size() < OD) m_out.push_back(r);
            else begin m_ovf = 1; drop = 1; end
         end
      end
      if (instr_req && instr_gnt) begin
         p.addr = instr_addr;
         p.req_start = m_open ? m_start : counter;
         p.req_end = counter;
         p.res_start = counter;
         if (m_pend.size() < MAXO) m_pend.push_back(p);
         else begin m_perr = 1; drop = 1; end
         m_open = 0;
      end else if (instr_req) begin
         if (!m_open) begin m_open = 1; m_start = counter; end
      end else begin
         m_open = 0;
      end
      if (drop && m_drop < 65535) m_drop++;
   endtask

   task automatic check_outputs();
      chk("trace_valid", trace_valid, m_out.size() > 0);
      if (m_out.size() > 0) chk("trace_data", trace_data, m_out[0]);
      chk("inflight_count", inflight_count, m_pend.size());
      chk("overflow", overflow, m_ovf);
      chk("proto_err", proto_err, m_perr);
`ifdef IFT_DROP_COUNT_EN
      chk("drop_count", drop_count, m_drop);
`endif
   endtask

   task automatic drv(logic r, logic g, logic [31:0] a, logic v, logic [31:0] d);
      instr_req = r; instr_gnt = g; instr_addr = a; instr_rvalid = v; instr_rdata = d;
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk); #1;
      check_outputs();
      counter = counter + 32'd1;
   endtask

   task automatic check_zero(string tag);
      chk({tag, "_valid"}, trace_valid, 1'b0);
      chk({tag, "_data"}, trace_data, '0);
      chk({tag, "_inflight"}, inflight_count, 3'd0);
      chk({tag, "_overflow"}, overflow, 1'b0);
      chk({tag, "_proto"}, proto_err, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drv(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      #1;
      check_zero("reset");
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      rst = 1'b0; trace_ready = 1'b0; counter = 32'd0;
      drv(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      #2;
      do_reset();

      // Single fetch: req at 10, gnt at 12, rvalid at 14.
      counter = 32'd10;
      drv(1'b1, 1'b0, 32'h0, 1'b0, 32'h0); cycle();
      cycle();
      drv(1'b1, 1'b1, 32'h80, 1'b0, 32'h0); cycle();
      drv(1'b0, 1'b0, 32'h0, 1'b0, 32'h0); cycle();
      drv(1'b0, 1'b0, 32'h0, 1'b1, 32'h13); cycle();
      chk("single_rec", trace_data, {32'h80, 32'h13, 32'd10, 32'd12, 32'd12, 32'd14});
      chk("single_valid", trace_valid, 1'b1);

      // Pipelined: four back-to-back grants then four responses.
      counter = 32'd20;
      trace_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drv(1'b1, 1'b1, 32'h100 + 32'(i * 4), 1'b0, 32'h0); cycle();
      end
      chk("pipe_peak", inflight_count, 3'd4);
      drv(1'b0, 1'b0, 32'h0, 1'b0, 32'h0); cycle();
      for (int i = 0; i < 4; i++) begin
         drv(1'b0, 1'b0, 32'h0, 1'b1, 32'hA000 + 32'(i)); cycle();
      end
      drv(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      for (int i = 0; i < 4; i++) cycle();
      chk("pipe_perr", proto_err, 1'b0);

      // Same-cycle grant and response with one fetch in flight.
      drv(1'b1, 1'b1, 32'h200, 1'b0, 32'h0); cycle();
      drv(1'b1, 1'b1, 32'h204, 1'b1, 32'h55); cycle();
      chk("same_inflight", inflight_count, 3'd1);
      chk("same_valid", trace_valid, 1'b1);
      drv(1'b0, 1'b0, 32'h0, 1'b1, 32'h66); cycle();
      drv(1'b0, 1'b0, 32'h0, 1'b0, 32'h0); cycle(); cycle();

      // Backpressure: nine fetches into an eight-deep output FIFO.
      trace_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         drv(1'b1, 1'b1, 32'h300 + 32'(i * 4), 1'b0, 32'h0); cycle();
         drv(1'b0, 1'b0, 32'h0, 1'b1, 32'hB000 + 32'(i)); cycle();
      end
      chk("bp_overflow", overflow, 1'b1);
`ifdef IFT_DROP_COUNT_EN
      chk("bp_drop_count", drop_count, 16'd1);
`endif
      drv(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      trace_ready = 1'b1;
      for (int i = 0; i < 9; i++) cycle();
      chk("bp_drained", trace_valid, 1'b0);

      // Protocol errors: orphan rvalid, then a fifth grant while full.
      do_reset();
      drv(1'b0, 1'b0, 32'h0, 1'b1, 32'h77); cycle();
      chk("orphan_perr", proto_err, 1'b1);
      chk("orphan_norec", trace_valid, 1'b0);
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drv(1'b1, 1'b1, 32'h400 + 32'(i * 4), 1'b0, 32'h0); cycle();
      end
      chk("full_noperr", proto_err, 1'b0);
      drv(1'b1, 1'b1, 32'h410, 1'b0, 32'h0); cycle();
      chk("full_perr", proto_err, 1'b1);
      chk("full_inflight", inflight_count, 3'd4);
      for (int i = 0; i < 4; i++) begin
         drv(1'b0, 1'b0, 32'h0, 1'b1, 32'hC000 + 32'(i)); cycle();
      end

      // Async reset with three in flight, then late responses.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drv(1'b1, 1'b1, 32'h500 + 32'(i * 4), 1'b0, 32'h0); cycle();
      end
      drv(1'b0, 1'b0, 32'h0, 1'b1, 32'hD000); cycle();
      #2;
      rst = 1'b1;
      #1;
      check_zero("async");
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 2; i++) begin
         drv(1'b0, 1'b0, 32'h0, 1'b1, 32'hD100 + 32'(i)); cycle();
      end
      chk("late_perr", proto_err, 1'b1);
      chk("late_norec", trace_valid, 1'b0);

      // Randomized traffic, counter near wrap.
      do_reset();
      counter = 32'hFFFF_FE00;
      for (int i = 0; i < 1500; i++) begin
         instr_req    = ($urandom_range(3) != 0);
         instr_gnt    = instr_req & ($urandom_range(1) == 1);
         instr_addr   = $urandom;
         instr_rvalid = ($urandom_range(4) < 2);
         instr_rdata  = $urandom;
         trace_ready  = ($urandom_range(9) < 7);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
